// File: rtl/pcpi_est_pkg.sv
// Shared definitions for the PCPI estimator sequencer: custom-opcode
// encodings, the CALCULATE match/mask pair, the FSM state type and a
// small elaboration-time helper.
package pcpi_est_pkg;

    localparam logic [6:0]  OPC_CUSTOM      = 7'h27;
    localparam logic [2:0]  F3_LOAD         = 3'd1;
    localparam logic [2:0]  F3_CALC         = 3'd2;
    localparam logic [2:0]  F3_CLEAR        = 3'd3;
    localparam logic [31:0] MATCH_CALCULATE = 32'h0000_2027;
    localparam logic [31:0] MASK_CALCULATE  = 32'hfe00_707f;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESP
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pcpi_est_sequencer_if.sv
// PicoRV32 co-processor (PCPI) handshake bundle.
//   master : CPU side   - drives valid/insn/rs1/rs2, receives wr/rd/wait/ready
//   slave  : co-processor side - the reverse
interface pcpi_est_sequencer_if;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
    );

endinterface

// File: rtl/pcpi_est_decode.sv
// Combinational instruction decoder for the estimator custom opcode.
//   pcpi_insn : instruction word
//   is_load   : LOAD command (funct3 = 1)
//   is_calc   : CALCULATE command (funct3 = 2)
//   is_clear  : CLEAR command (funct3 = 3)
// Anything else, including other funct3 values, decodes to no command.
module pcpi_est_decode
    import pcpi_est_pkg::*;
(
    input  logic [31:0] pcpi_insn,
    output logic        is_load,
    output logic        is_calc,
    output logic        is_clear
);

    logic base_hit;
    logic unused_fields;

    assign base_hit = (pcpi_insn[6:0] == OPC_CUSTOM) && (pcpi_insn[31:25] == 7'd0);

    assign is_load  = base_hit && (pcpi_insn[14:12] == F3_LOAD);
    assign is_calc  = (pcpi_insn & MASK_CALCULATE) == MATCH_CALCULATE;
    assign is_clear = base_hit && (pcpi_insn[14:12] == F3_CLEAR);

    // register-select fields carry no meaning for these commands
    assign unused_fields = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

endmodule

// File: rtl/pcpi_est_sequencer.sv
// PCPI sequencer for the estimator datapath. Claims LOAD / CALCULATE /
// CLEAR custom instructions and drives the datapath control strobes.
//   clk_n, reset  : clock (rising edge) and synchronous active-high reset
//   pcpi          : PCPI handshake, slave side
//   ld_en/ld_data : push control vector into the sample buffer
//   dp_clear      : clear the datapath accumulator
//   calc_en/idx   : adder-tree input enable and S3 group index
//   dp_result     : adder-tree output
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for a matching, unblocked pcpi_valid
// ST_LOAD  | ld_en high for one cycle
// ST_CLEAR | dp_clear high for one cycle
// ST_ISSUE | calc_en high, feeding group cnt_q
// ST_DRAIN | waiting out the adder-tree latency
// ST_RESP  | pcpi_ready pulse (pcpi_wr for CALCULATE)
module pcpi_est_sequencer
    import pcpi_est_pkg::*;
#(
    parameter  int N                = 8,
    parameter  int NUM_ADD_CLK      = 4,
    parameter  int NUM_ADDER_STAGES = 6,
    parameter  int WIDTH_RESULT     = 32,
    localparam int CIW              = (NUM_ADD_CLK > 1) ? $clog2(NUM_ADD_CLK) : 1
) (
    input  logic                    clk_n,
    input  logic                    reset,
    pcpi_est_sequencer_if.slave     pcpi,
    output logic                    ld_en,
    output logic [N-1:0]            ld_data,
    output logic                    dp_clear,
    output logic                    calc_en,
    output logic [CIW-1:0]          calc_idx,
    input  logic [WIDTH_RESULT-1:0] dp_result
);

    localparam int CW = $clog2(max_int(NUM_ADD_CLK, NUM_ADDER_STAGES)) + 1;
    localparam logic [CW-1:0] ISSUE_LAST = CW'(NUM_ADD_CLK - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(NUM_ADDER_STAGES - 1);

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [WIDTH_RESULT-1:0] res_q;
    logic                    blk_q;       // accept_block
    logic                    clr_pend_q;  // discard pulse owed after an abort
    logic [N-1:0]            ld_data_q;
    logic                    ld_en_q, dp_clear_q, calc_en_q;
    logic [CIW-1:0]          calc_idx_q;
    logic                    wait_q, ready_q, wr_q;

    logic is_load, is_calc, is_clear;
    logic unused_ops;

    pcpi_est_decode u_decode (
        .pcpi_insn (pcpi.pcpi_insn),
        .is_load   (is_load),
        .is_calc   (is_calc),
        .is_clear  (is_clear)
    );

    always_ff @(posedge clk_n) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            res_q      <= '0;
            blk_q      <= 1'b0;
            clr_pend_q <= 1'b0;
            ld_data_q  <= '0;
            ld_en_q    <= 1'b0;
            dp_clear_q <= 1'b0;
            calc_en_q  <= 1'b0;
            calc_idx_q <= '0;
            wait_q     <= 1'b0;
            ready_q    <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            ld_en_q    <= 1'b0;
            dp_clear_q <= clr_pend_q;
            clr_pend_q <= 1'b0;
            calc_en_q  <= 1'b0;
            calc_idx_q <= '0;
            wait_q     <= 1'b0;
            ready_q    <= 1'b0;
            wr_q       <= 1'b0;
            blk_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (pcpi.pcpi_valid && !blk_q && (is_load || is_calc || is_clear)) begin
                        ld_data_q <= pcpi.pcpi_rs1[N-1:0];
                        cnt_q     <= '0;
                        wait_q    <= 1'b1;
                        if (is_load) begin
                            state_q <= ST_LOAD;
                            ld_en_q <= 1'b1;
                        end else if (is_clear) begin
                            state_q    <= ST_CLEAR;
                            dp_clear_q <= 1'b1;
                        end else begin
                            state_q   <= ST_ISSUE;
                            calc_en_q <= 1'b1;
                        end
                    end
                end

                ST_LOAD, ST_CLEAR, ST_ISSUE, ST_DRAIN: begin
                    if (!pcpi.pcpi_valid) begin
                        // Abort. Blocking the next cycle keeps the owed clear
                        // pulse from landing on top of a freshly accepted command.
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        clr_pend_q <= 1'b1;
                        blk_q      <= 1'b1;
                    end else if (state_q == ST_LOAD || state_q == ST_CLEAR) begin
                        state_q <= ST_RESP;
                        ready_q <= 1'b1;
                    end else if (state_q == ST_ISSUE) begin
                        wait_q <= 1'b1;
                        if (cnt_q == ISSUE_LAST) begin
                            state_q <= ST_DRAIN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q      <= cnt_q + 1'b1;
                            calc_en_q  <= 1'b1;
                            calc_idx_q <= CIW'(cnt_q + 1'b1);
                        end
                    end else begin
                        if (cnt_q == DRAIN_LAST) begin
                            res_q   <= dp_result;
                            state_q <= ST_RESP;
                            cnt_q   <= '0;
                            ready_q <= 1'b1;
                            wr_q    <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + 1'b1;
                            wait_q <= 1'b1;
                        end
                    end
                end

                ST_RESP: begin
                    // pcpi_valid of the finished instruction is still high next cycle
                    state_q <= ST_IDLE;
                    blk_q   <= 1'b1;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ld_en           = ld_en_q;
    assign ld_data         = ld_data_q;
    assign dp_clear        = dp_clear_q;
    assign calc_en         = calc_en_q;
    assign calc_idx        = calc_idx_q;
    assign pcpi.pcpi_wait  = wait_q;
    assign pcpi.pcpi_ready = ready_q;
    assign pcpi.pcpi_wr    = wr_q;
    assign pcpi.pcpi_rd    = wr_q ? 32'($signed(res_q)) : 32'd0;

    assign unused_ops = ^{pcpi.pcpi_rs2, pcpi.pcpi_rs1[31:N]};

endmodule

// File: tb/tb_pcpi_est_sequencer.sv
module tb_pcpi_est_sequencer;

    localparam int W = 22;

    logic         clk_n = 1'b0;
    logic         reset;
    logic         ld_en;
    logic [7:0]   ld_data;
    logic         dp_clear;
    logic         calc_en;
    logic [1:0]   calc_idx;
    logic [W-1:0] dp_result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] dpr_h [0:127];

    always #5 clk_n = ~clk_n;

    pcpi_est_sequencer_if bus ();

    pcpi_est_sequencer #(
        .N                (8),
        .NUM_ADD_CLK      (4),
        .NUM_ADDER_STAGES (6),
        .WIDTH_RESULT     (W)
    ) dut (
        .clk_n     (clk_n),
        .reset     (reset),
        .pcpi      (bus),
        .ld_en     (ld_en),
        .ld_data   (ld_data),
        .dp_clear  (dp_clear),
        .calc_en   (calc_en),
        .calc_idx  (calc_idx),
        .dp_result (dp_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [W-1:0] v);
        logic [31:0] z;
        z = 32'(v);
        return v[W-1] ? (z | (32'hFFFF_FFFF << W)) : z;
    endfunction

    // kind: 0 LOAD, 1 CLEAR, 2 CALC, 3 bad funct3, 4 bad funct7, 5 other opcode
    function automatic logic [31:0] make_insn(input int kind);
        logic [31:0] i;
        logic [2:0]  bad_f3 [5];
        bad_f3 = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};
        i = $urandom;
        i[6:0]   = 7'h27;
        i[31:25] = 7'd0;
        case (kind)
            0: i[14:12] = 3'd1;
            1: i[14:12] = 3'd3;
            2: i[14:12] = 3'd2;
            3: i[14:12] = bad_f3[$urandom_range(4)];
            4: begin
                i[14:12] = 3'(1 + $urandom_range(2));
                i[31:25] = 7'(1 + $urandom_range(126));
            end
            default: begin
                i[14:12] = 3'(1 + $urandom_range(2));
                i[6:0]   = 7'h27 ^ 7'(1 + $urandom_range(126));
            end
        endcase
        return i;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_wait"},  32'(bus.pcpi_wait),  32'd0);
        chk({tag, "_ready"}, 32'(bus.pcpi_ready), 32'd0);
        chk({tag, "_wr"},    32'(bus.pcpi_wr),    32'd0);
        chk({tag, "_rd"},    bus.pcpi_rd,         32'd0);
        chk({tag, "_ld_en"}, 32'(ld_en),          32'd0);
        chk({tag, "_clr"},   32'(dp_clear),       32'd0);
        chk({tag, "_calc"},  32'(calc_en),        32'd0);
        chk({tag, "_idx"},   32'(calc_idx),       32'd0);
    endtask

    // One command from the CPU's point of view. Called on a negedge with
    // the sequencer idle and unblocked.
    //   ab     : cycle (1-based after accept) in which valid is dropped, 0 = none
    //   rst_at : cycle in which reset is raised, 0 = none
    //   reps   : 2 = keep valid high for a second identical command
    task automatic run_txn(input int kind, input logic [31:0] rs1, input int ab,
                           input int rst_at, input int reps, input bit fix_dpr,
                           input logic [W-1:0] dpr_val);
        bit          good;
        int          lat, r, total, c, base;
        logic [31:0] insn;
        logic        e_wait, e_ready, e_wr, e_ld, e_clr, e_calc;
        logic [31:0] e_idx, e_rd;

        good  = (kind <= 2);
        lat   = (kind == 2) ? 10 : 1;
        r     = lat + 1;
        if (!good)          total = 20;
        else if (reps == 2) total = 2 * r + 6;
        else                total = r + 4;

        insn = make_insn(kind);
        bus.pcpi_insn  = insn;
        bus.pcpi_rs1   = rs1;
        bus.pcpi_rs2   = $urandom;
        bus.pcpi_valid = 1'b1;
        dp_result      = fix_dpr ? dpr_val : W'($urandom);
        dpr_h[0]       = dp_result;

        for (int k = 1; k <= total; k++) begin
            @(negedge clk_n);
            e_wait = 0; e_ready = 0; e_wr = 0; e_ld = 0; e_clr = 0; e_calc = 0;
            e_idx = 0; e_rd = 0;
            if (good) begin
                c    = k;
                base = 0;
                if (reps == 2 && k > r + 2) begin
                    c    = k - (r + 2);
                    base = r + 2;
                end
                if (rst_at > 0 && c > rst_at) begin
                end else if (ab > 0 && c > ab) begin
                    e_clr = (c == ab + 2);
                end else if (c <= lat) begin
                    e_wait = 1;
                    if (kind == 0) e_ld  = (c == 1);
                    if (kind == 1) e_clr = (c == 1);
                    if (kind == 2 && c <= 4) begin
                        e_calc = 1;
                        e_idx  = 32'(c - 1);
                    end
                end else if (c == r) begin
                    e_ready = 1;
                    if (kind == 2) begin
                        e_wr = 1;
                        e_rd = sext(dpr_h[base + 10]);
                    end
                end
            end
            chk("wait",  32'(bus.pcpi_wait),  32'(e_wait));
            chk("ready", 32'(bus.pcpi_ready), 32'(e_ready));
            chk("wr",    32'(bus.pcpi_wr),    32'(e_wr));
            chk("rd",    bus.pcpi_rd,         e_rd);
            chk("ld_en", 32'(ld_en),          32'(e_ld));
            chk("clr",   32'(dp_clear),       32'(e_clr));
            chk("calc",  32'(calc_en),        32'(e_calc));
            chk("idx",   32'(calc_idx),       e_idx);
            if (e_ld) chk("ld_data", 32'(ld_data), 32'(rs1[7:0]));

            if (!good)             bus.pcpi_valid = (k < 20);
            else if (ab > 0)       bus.pcpi_valid = (k < ab);
            else if (rst_at > 0)   bus.pcpi_valid = (k < rst_at);
            else if (reps == 2)    bus.pcpi_valid = (k < 2 * r + 3);
            else                   bus.pcpi_valid = (k < r + 1);
            if (rst_at > 0) reset = (k == rst_at);
            dp_result = fix_dpr ? dpr_val : W'($urandom);
            dpr_h[k]  = dp_result;
        end
        bus.pcpi_valid = 1'b0;
        reset          = 1'b0;
    endtask

    initial begin
        int kind, ab, rst_at, reps, lat;

        reset          = 1'b1;
        bus.pcpi_valid = 1'b0;
        bus.pcpi_insn  = 32'd0;
        bus.pcpi_rs1   = 32'd0;
        bus.pcpi_rs2   = 32'd0;
        dp_result      = '0;

        repeat (3) @(negedge clk_n);
        check_idle("rst");
        reset = 1'b0;
        @(negedge clk_n);
        check_idle("post_rst");
        chk("post_rst_ld_data", 32'(ld_data), 32'd0);

        // directed cases
        run_txn(0, 32'h0000_00A5, 0, 0, 1, 1'b0, '0);        // LOAD A5
        run_txn(2, $urandom, 0, 0, 1, 1'b1, 22'h3FFFFF);     // CALC, all-ones result
        run_txn(3, $urandom, 0, 0, 1, 1'b0, '0);             // bad funct3
        run_txn(4, $urandom, 0, 0, 1, 1'b0, '0);             // bad funct7
        run_txn(2, $urandom, 0, 0, 2, 1'b0, '0);             // back-to-back CALC
        run_txn(2, $urandom, 2, 0, 1, 1'b0, '0);             // abort in ISSUE cycle 2
        run_txn(2, $urandom, 0, 7, 1, 1'b0, '0);             // reset in DRAIN
        run_txn(1, $urandom, 0, 0, 1, 1'b0, '0);             // CLEAR
        run_txn(0, $urandom, 1, 0, 1, 1'b0, '0);             // abort in LOAD

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            kind   = $urandom_range(5);
            lat    = (kind == 2) ? 10 : 1;
            ab     = 0;
            rst_at = 0;
            reps   = 1;
            if (kind <= 2) begin
                case ($urandom_range(5))
                    0: ab     = 1 + $urandom_range(lat - 1);
                    1: rst_at = 1 + $urandom_range(lat - 1);
                    2: reps   = 2;
                    default: ;
                endcase
            end
            run_txn(kind, $urandom, ab, rst_at, reps, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcpi_est_sequencer.md
PCPI_EST_SEQUENCER -- requirements
Module: pcpi_est_sequencer

Interface
REQ-001 Parameter N, default 8: control-vector width loaded per LOAD command.
REQ-002 Parameter NUM_ADD_CLK, default 4: cycles needed to feed all S3 adder groups per calculation.
REQ-003 Parameter NUM_ADDER_STAGES, default 6: pipeline latency of the adder tree, in cycles.
REQ-004 Parameter WIDTH_RESULT, default 32: datapath result width, WIDTH_RESULT <= 32.
REQ-005 clk_n  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pcpi_valid  in  1  PicoRV32 co-processor instruction valid.
REQ-008 pcpi_insn  in  32  instruction word.
REQ-009 pcpi_rs1  in  32  source operand 1.
REQ-010 pcpi_rs2  in  32  source operand 2; unused, reserved.
REQ-011 pcpi_wr  out  1  write pcpi_rd to rd; valid with pcpi_ready.
REQ-012 pcpi_rd  out  32  result, sign-extended from WIDTH_RESULT.
REQ-013 pcpi_wait  out  1  command claimed, busy.
REQ-014 pcpi_ready  out  1  command complete, one-cycle pulse.
REQ-015 ld_en  out  1  push ld_data into the datapath sample buffer.
REQ-016 ld_data  out  N  control vector, equal to rs1[N-1:0] captured at accept.
REQ-017 dp_clear  out  1  clear the datapath accumulator.
REQ-018 calc_en  out  1  adder-tree input enable.
REQ-019 calc_idx  out  $clog2(NUM_ADD_CLK) (min 1)  S3 group index being fed.
REQ-020 dp_result  in  WIDTH_RESULT  adder-tree output, valid NUM_ADDER_STAGES cycles after the last calc_en.

Function
REQ-021 A command matches when opcode = 7'h27 and funct7 = 0.
REQ-022 funct3 selects the command: 1 = LOAD, 2 = CALCULATE (match 32'h2027, mask 32'hfe00707f), 3 = CLEAR.
REQ-023 A matching instruction with any other funct3, or a non-matching instruction, is never claimed: pcpi_wait and pcpi_ready stay 0.
REQ-024 The FSM has states IDLE, LOAD, CLEAR, ISSUE, DRAIN and RESP.
REQ-025 Accept edge: the IDLE edge with pcpi_valid=1, a matching command and accept_block=0.
REQ-026 At the accept edge, rs1[N-1:0] is captured into ld_data and the state moves to LOAD, CLEAR or ISSUE according to funct3.
REQ-027 pcpi_wait = 1 in every state except IDLE and RESP.
REQ-028 LOAD: ld_en = 1 for exactly one cycle, then RESP.
REQ-029 CLEAR: dp_clear = 1 for exactly one cycle, then RESP.
REQ-030 ISSUE: calc_en = 1 for NUM_ADD_CLK consecutive cycles, with calc_idx = 0,1,...,NUM_ADD_CLK-1; then DRAIN.
REQ-031 DRAIN: lasts NUM_ADDER_STAGES cycles; dp_result is registered on the final DRAIN edge; then RESP.
REQ-032 RESP: one cycle with pcpi_ready = 1.
REQ-033 In RESP, pcpi_wr = 1 only for CALCULATE; pcpi_rd = sign-extended registered result for CALCULATE, otherwise 0.
REQ-034 Latency from accept edge to pcpi_ready: LOAD 2 cycles, CLEAR 2 cycles, CALCULATE NUM_ADD_CLK+NUM_ADDER_STAGES+1 cycles.
REQ-035 accept_block = 1 in the cycle after RESP, so the still-asserted pcpi_valid of the completed instruction is not re-accepted.
REQ-036 If pcpi_valid falls in LOAD, CLEAR, ISSUE or DRAIN, the FSM aborts to IDLE on the next edge.
REQ-037 On abort: no pcpi_ready; calc_en, ld_en and dp_clear drop immediately; dp_clear pulses once on the following cycle to discard partial sums.
REQ-038 Outputs ld_en, dp_clear, calc_en, pcpi_wait, pcpi_ready and pcpi_wr are glitch-free decodes of registered state.

Reset
REQ-039 With reset high at an edge: state = IDLE, counters = 0, result register = 0, accept_block = 0.
REQ-040 After reset, every output is 0.
REQ-041 reset takes priority over any in-flight command; no pcpi_ready is issued for the interrupted command.

Structure
REQ-042 A shared package pcpi_est_pkg holds: OPC_CUSTOM = 7'h27, F3_LOAD/F3_CALC/F3_CLEAR, MATCH_CALCULATE, MASK_CALCULATE, and the state enum.
REQ-043 Sub-module pcpi_est_decode is purely combinational; it outputs is_load, is_calc and is_clear from pcpi_insn.
REQ-044 A single cycle counter, width $clog2(max(NUM_ADD_CLK, NUM_ADDER_STAGES))+1, is reused by ISSUE and DRAIN.

Verification
REQ-045 CALCULATE (insn 32'h00002027), valid held, dp_result = 22'h3FFFFF at WIDTH_RESULT=22 -> calc_en high 4 cycles (idx 0..3), pcpi_ready on the 11th cycle after accept, pcpi_wr=1, pcpi_rd = 32'hFFFFFFFF.
REQ-046 LOAD (insn 32'h00001027), rs1 = 32'h000000A5 -> ld_en pulse 1 cycle with ld_data = 8'hA5, pcpi_ready 2 cycles after accept, pcpi_wr = 0.
REQ-047 Insn 32'h00004027 (funct3=4) and 32'h02002027 (funct7=1), each held 20 cycles -> pcpi_wait = 0 and pcpi_ready = 0 throughout.
REQ-048 Two back-to-back CALCULATE with valid held through the RESP+1 cycle -> exactly one pcpi_ready per instruction; the second is accepted no earlier than 2 cycles after the first pcpi_ready.
REQ-049 CALCULATE with pcpi_valid dropped in ISSUE cycle 2 -> IDLE next edge, one dp_clear pulse, no pcpi_ready.
REQ-050 Same stimulus with reset asserted in DRAIN instead -> all outputs 0 the next cycle, no pcpi_ready.
